mandel_pixel_sched: RTL

- Frame-level scheduler between the keyboard/view front end and a pool of NUM_ENG Mandelbrot iteration engines.
- On start it walks the screen in raster order and dispatches each pixel to a free engine.
- It collects each engine's iteration count, colour-maps it, and round-robin arbitrates the results onto the single frame-buffer write port (addrA/dinA/wea).

---
 rtl/mandel_pkg.sv | 23 ++
 rtl/mandel_pixel_sched_if.sv | 28 ++
 rtl/mandel_rr_arbiter.sv | 41 ++++
 rtl/mandel_pixel_sched.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/mandel_pkg.sv
// Shared definitions for the Mandelbrot pixel scheduler: screen defaults,
// scheduler states and the iteration-count to RGB444 colour map.
package mandel_pkg;

  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;
  localparam int RGB_W     = 12;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DISPATCH,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Points that reached the iteration limit are inside the set and drawn black.
  function automatic logic [RGB_W-1:0] colour_map(input logic [7:0] res,
                                                  input logic [7:0] max_ite);
    if (res >= max_ite) return '0;
    return {res[3:0], res[5:2], res[7:4]};
  endfunction

endpackage

// File: rtl/mandel_pixel_sched_if.sv
// Engine dispatch/collect signals and the frame-buffer write port.
// master: the scheduler; slave: the engine pool plus frame buffer.
interface mandel_pixel_sched_if #(
  parameter int NUM_ENG = 4,
  parameter int ADDR_W  = 19
);
  import mandel_pkg::*;

  logic [NUM_ENG-1:0]   eng_start;
  logic [9:0]           eng_x;
  logic [8:0]           eng_y;
  logic [7:0]           eng_max;
  logic [NUM_ENG-1:0]   eng_done;
  logic [NUM_ENG*8-1:0] eng_ite;
  logic [ADDR_W-1:0]    addrA;
  logic [RGB_W-1:0]     dinA;
  logic                 wea;

  modport master (
    output eng_start, eng_x, eng_y, eng_max, addrA, dinA, wea,
    input  eng_done, eng_ite
  );

  modport slave (
    input  eng_start, eng_x, eng_y, eng_max, addrA, dinA, wea,
    output eng_done, eng_ite
  );
endinterface

// File: rtl/mandel_rr_arbiter.sv
// Round-robin arbiter: the search starts just after the last granted index.
// advance commits the current grant as the new starting point.
module mandel_rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  input  logic         advance
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] last;
  logic [IW-1:0] grant_idx;
  logic [N-1:0]  above;
  logic [N-1:0]  hi_req;

  // Prefer requests above the last grant; wrap to the lowest request otherwise.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    above = '0;
    for (int i = 0; i < N; i++) above[i] = (i > int'(last));
    hi_req = req & above;
    if (|hi_req) grant = hi_req & (~hi_req + N'(1));
    else         grant = req & (~req + N'(1));
  end

  // Encode the one-hot grant for the pointer update.
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < N; i++) if (grant[i]) grant_idx = IW'(i);
  end

  // Pointer resets to the top index so the first search begins at index 0.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset)                 last <= IW'(N - 1);
    else if (advance && |grant) last <= grant_idx;
  end
endmodule

// File: rtl/mandel_pixel_sched.sv
// Frame scheduler: walks the screen in raster order, dispatches pixels to the
// lowest free engine, collects results and writes colour-mapped pixels to the
// frame buffer one per cycle in round-robin order.
// Optional macro MANDEL_SCHED_STATS_EN adds a per-frame cycle counter.
module mandel_pixel_sched
  import mandel_pkg::*;
#(
  parameter int NUM_ENG = 4,
  parameter int H_RES   = H_RES_DEF,
  parameter int V_RES   = V_RES_DEF,
  parameter int ADDR_W  = 19
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [7:0]           max_ite,
  output logic                 busy,
  output logic                 frame_done,
  output logic [8:0]           remain,
  output logic [31:0]          frame_cycles,
  mandel_pixel_sched_if.master bus
);
  localparam int         IW     = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
  localparam logic [9:0] X_LAST = 10'(H_RES - 1);
  localparam logic [8:0] Y_LAST = 9'(V_RES - 1);
  localparam logic [8:0] V_ROWS = 9'(V_RES);

  state_t state, state_nxt;

  logic [9:0]        x;
  logic [8:0]        y;
  logic [ADDR_W-1:0] addr;

  logic [NUM_ENG-1:0] outstanding, pending;
  logic [NUM_ENG-1:0] free, sel_oh, set_mask, done_mask, grant;
  logic [IW-1:0]      grant_idx;
  logic               dispatch, last_pix;

  logic [ADDR_W-1:0] tag [NUM_ENG];
  logic [7:0]        res [NUM_ENG];

  logic [NUM_ENG-1:0] eng_start_q;
  logic [9:0]         eng_x_q;
  logic [8:0]         eng_y_q;
  logic [7:0]         eng_max_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [RGB_W-1:0]   din_q;
  logic               wea_q;

  // Engine selection, result capture masks and grant index.
  always_comb begin
    free      = ~outstanding & ~pending;
    sel_oh    = free & (~free + NUM_ENG'(1));
    dispatch  = (state == ST_DISPATCH) && (|free);
    set_mask  = dispatch ? sel_oh : '0;
    done_mask = bus.eng_done & outstanding;
    last_pix  = (x == X_LAST) && (y == Y_LAST);
    grant_idx = '0;
    for (int i = 0; i < NUM_ENG; i++) if (grant[i]) grant_idx = IW'(i);
  end

  mandel_rr_arbiter #(.N(NUM_ENG)) u_wb_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (pending),
    .grant   (grant),
    .advance (|pending)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (start) state_nxt = ST_DISPATCH;
      ST_DISPATCH: if (dispatch && last_pix) state_nxt = ST_DRAIN;
      ST_DRAIN:    if (~|outstanding && ~|pending) state_nxt = ST_DONE;
      ST_DONE:     state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // Raster counters, engine flags and registered engine/frame-buffer outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x           <= '0;
      y           <= '0;
      addr        <= '0;
      outstanding <= '0;
      pending     <= '0;
      eng_start_q <= '0;
      eng_x_q     <= '0;
      eng_y_q     <= '0;
      eng_max_q   <= '0;
      addr_q      <= '0;
      din_q       <= '0;
      wea_q       <= 1'b0;
    end else begin
      eng_start_q <= set_mask;
      if (state == ST_IDLE && start) begin
        x         <= '0;
        y         <= '0;
        addr      <= '0;
        eng_max_q <= max_ite;
      end
      if (dispatch) begin
        eng_x_q <= x;
        eng_y_q <= y;
        addr    <= addr + ADDR_W'(1);
        if (x == X_LAST) begin
          x <= '0;
          y <= y + 9'd1;
        end else begin
          x <= x + 10'd1;
        end
      end
      outstanding <= (outstanding | set_mask) & ~done_mask;
      pending     <= (pending | done_mask) & ~grant;
      wea_q       <= |grant;
      if (|grant) begin
        addr_q <= tag[grant_idx];
        din_q  <= colour_map(res[grant_idx], eng_max_q);
      end
    end
  end

  // Per-engine pixel address and result; only read while the engine's flag is set.
  always_ff @(posedge clk) begin
    // NOTE: these arrays carry no reset; outstanding/pending qualify every read, so stale contents are never used.
    for (int i = 0; i < NUM_ENG; i++) begin
      if (set_mask[i])  tag[i] <= addr;
      if (done_mask[i]) res[i] <= bus.eng_ite[i*8 +: 8];
    end
  end

  assign busy       = (state != ST_IDLE);
  assign frame_done = (state == ST_DONE);
  assign remain     = (state == ST_IDLE) ? 9'd0 : V_ROWS - y;

  assign bus.eng_start = eng_start_q;
  assign bus.eng_x     = eng_x_q;
  assign bus.eng_y     = eng_y_q;
  assign bus.eng_max   = eng_max_q;
  assign bus.addrA     = addr_q;
  assign bus.dinA      = din_q;
  assign bus.wea       = wea_q;

`ifdef MANDEL_SCHED_STATS_EN
  logic [31:0] cyc_cnt;
  logic [31:0] frame_cycles_q;

  // Saturating count of non-idle cycles, published when the frame completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_cnt        <= '0;
      frame_cycles_q <= '0;
    end else begin
      if (state == ST_IDLE) begin
        if (start) cyc_cnt <= '0;
      end else if (cyc_cnt != 32'hFFFF_FFFF) begin
        cyc_cnt <= cyc_cnt + 32'd1;
      end
      if (state == ST_DONE) frame_cycles_q <= cyc_cnt;
    end
  end

  assign frame_cycles = frame_cycles_q;
`else
  assign frame_cycles = '0;
`endif
endmodule
